// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings, HALT opcode, word framing.
// Imported by the loader top and its byte assembler.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [5:0] HALT_OPCODE    = 6'b111111;
  localparam int         BYTES_PER_WORD = 4;
  localparam int         BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  function automatic logic is_halt(input logic [5:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// master = byte source / memory side, slave = the loader itself.
interface program_loader_if #(
  parameter int len_addr = 11,
  parameter int len_data = 32
);
  logic                start;
  logic                rx_done;
  logic [7:0]          rx_data;
  logic                Wr;
  logic [len_addr-1:0] Addr;
  logic [len_data-1:0] In_Data;
  logic                busy;
  logic                load_done;
  logic [len_addr:0]   word_count;

  modport master (
    output start, rx_done, rx_data,
    input  Wr, Addr, In_Data, busy, load_done, word_count
  );

  modport slave (
    input  start, rx_done, rx_data,
    output Wr, Addr, In_Data, busy, load_done, word_count
  );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Big-endian byte-to-word assembler: word_stb/word_dat are combinational on the last byte,
// word_vld is a registered one-cycle pulse the cycle after the word completes.
module byte_assembler
  import program_loader_pkg::*;
#(
  parameter int len_data = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                byte_vld,
  input  logic [7:0]          byte_dat,
  output logic                word_stb,
  output logic [len_data-1:0] word_dat,
  output logic                word_vld
);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [BYTE_CNT_W-1:0] CNT_ONE   = 1;

  logic [len_data-9:0]   shift_q;
  logic [BYTE_CNT_W-1:0] byte_cnt;

  assign word_stb = byte_vld && (byte_cnt == LAST_BYTE);
  assign word_dat = {shift_q, byte_dat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      byte_cnt <= '0;
      word_vld <= 1'b0;
    end else if (clr) begin
      shift_q  <= '0;
      byte_cnt <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= word_stb;
      if (byte_vld) begin
        // Older bytes move toward the MSBs, so the first byte lands in the top byte.
        shift_q  <= word_dat[len_data-9:0];
        byte_cnt <= word_stb ? '0 : byte_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: writes big-endian words from a byte stream into instruction memory until HALT or full.
// Optional macro LOADER_TIMEOUT_EN: a partial word idle for timeout_cycles in RECV is discarded.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int len_addr  = 11,
  parameter int len_data  = 32,
  parameter int ram_depth = 2048
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int timeout_cycles = 100000
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  program_loader_if.slave bus
);

  localparam logic [len_addr-1:0] LAST_ADDR = len_addr'(ram_depth - 1);
  localparam logic [len_addr-1:0] ADDR_ONE  = 1;
  localparam logic [len_addr:0]   WC_ONE    = 1;

  state_t              state;
  logic                wr_q;
  logic [len_addr-1:0] addr_q;
  logic [len_data-1:0] data_q;
  logic                busy_q;
  logic                done_q;
  logic [len_addr:0]   wc_q;

  logic                rx_ok;
  logic                load_go;
  logic                timeout;
  logic                asm_clr;
  logic                word_stb;
  logic                word_vld;
  logic [len_data-1:0] word_dat;

  assign rx_ok   = bus.rx_done && (state == ST_RECV);
  assign load_go = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign asm_clr = load_go || timeout;

  byte_assembler #(
    .len_data (len_data)
  ) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (asm_clr),
    .byte_vld (rx_ok),
    .byte_dat (bus.rx_data),
    .word_stb (word_stb),
    .word_dat (word_dat),
    .word_vld (word_vld)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int             TO_W    = $clog2(timeout_cycles + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeout_cycles - 1);
  localparam logic [TO_W-1:0] TO_ONE  = 1;

  logic [TO_W-1:0] idle_cnt;

  assign timeout = (state == ST_RECV) && !rx_ok && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != ST_RECV) || rx_ok || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_ONE;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wc_q   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state  <= ST_RECV;
            addr_q <= '0;
            wc_q   <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        ST_RECV: begin
          // Data is captured one edge ahead of Wr so the memory sees it settled.
          if (word_stb) begin
            data_q <= word_dat;
          end
          if (word_vld) begin
            state <= ST_WRITE;
            wr_q  <= 1'b1;
          end
        end
        ST_WRITE: begin
          state <= ST_HOLD;
          wr_q  <= 1'b0;
        end
        ST_HOLD: begin
          wc_q <= wc_q + WC_ONE;
          if (is_halt(data_q[len_data-1 -: 6]) || (addr_q == LAST_ADDR)) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_ONE;
            state  <= ST_RECV;
          end
        end
        default: begin
          state <= ST_IDLE;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Wr         = wr_q;
  assign bus.Addr       = addr_q;
  assign bus.In_Data    = data_q;
  assign bus.busy       = busy_q;
  assign bus.load_done  = done_q;
  assign bus.word_count = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of loads, hand-written corner sequences and random loads
// checked against a word-level model; one instance with ram_depth=2048, one with ram_depth=4.
module tb_program_loader;
  import program_loader_pkg::*;

  typedef logic [31:0] words_t [8];

  typedef struct {
    logic [10:0] a_pre;
    logic [31:0] d_pre;
    logic [10:0] a;
    logic [31:0] d;
    logic [10:0] a_post;
    logic [31:0] d_post;
    logic        wr_post;
  } wr_t;

  typedef struct {
    int     sel;
    int     n;
    words_t w;
    int     exp_n;
    bit     exp_done;
  } vec_t;

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_CYC = 40;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  program_loader_if #(.len_addr(11), .len_data(32)) bus0 ();
  program_loader_if #(.len_addr(11), .len_data(32)) bus1 ();

  program_loader #(
    .len_addr (11),
    .len_data (32),
    .ram_depth(2048)
`ifdef LOADER_TIMEOUT_EN
    ,
    .timeout_cycles(TO_CYC)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  program_loader #(
    .len_addr (11),
    .len_data (32),
    .ram_depth(4)
  ) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  logic        wr_s   [2];
  logic [10:0] addr_s [2];
  logic [31:0] dat_s  [2];
  logic        busy_s [2];
  logic        done_s [2];
  logic [11:0] wc_s   [2];

  assign wr_s[0] = bus0.Wr;      assign wr_s[1] = bus1.Wr;
  assign addr_s[0] = bus0.Addr;  assign addr_s[1] = bus1.Addr;
  assign dat_s[0] = bus0.In_Data; assign dat_s[1] = bus1.In_Data;
  assign busy_s[0] = bus0.busy;  assign busy_s[1] = bus1.busy;
  assign done_s[0] = bus0.load_done; assign done_s[1] = bus1.load_done;
  assign wc_s[0] = bus0.word_count; assign wc_s[1] = bus1.word_count;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Write monitor: records each Wr pulse with Addr/In_Data one cycle before, at, and after the rise.
  wr_t  wq0[$];
  wr_t  wq1[$];
  wr_t  cap  [2];
  logic pend [2];
  logic wr_p [2];
  logic [10:0] addr_p [2];
  logic [31:0] dat_p  [2];

  initial begin
    for (int s = 0; s < 2; s++) begin
      pend[s] = 1'b0; wr_p[s] = 1'b0; addr_p[s] = '0; dat_p[s] = '0;
    end
  end

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst_n) begin
        pend[s] = 1'b0;
      end else if (pend[s]) begin
        cap[s].a_post  = addr_s[s];
        cap[s].d_post  = dat_s[s];
        cap[s].wr_post = wr_s[s];
        if (s == 0) wq0.push_back(cap[s]); else wq1.push_back(cap[s]);
        pend[s] = 1'b0;
      end else if (wr_s[s] && !wr_p[s]) begin
        cap[s].a_pre = addr_p[s];
        cap[s].d_pre = dat_p[s];
        cap[s].a     = addr_s[s];
        cap[s].d     = dat_s[s];
        pend[s] = 1'b1;
      end
      wr_p[s]   = wr_s[s];
      addr_p[s] = addr_s[s];
      dat_p[s]  = dat_s[s];
    end
  end

  // Word-level reference: words are written in order until a HALT word or the memory is full.
  function automatic void model(input words_t w, input int n, input int depth,
                                output int exp_n, output bit exp_done);
    exp_n = 0;
    exp_done = 1'b0;
    for (int i = 0; i < n && !exp_done; i++) begin
      exp_n++;
      if (w[i][31:26] == 6'h3f || exp_n == depth) exp_done = 1'b1;
    end
  endfunction

  task automatic drive(input int sel, input logic st, input logic rv, input logic [7:0] d);
    if (sel == 0) begin
      bus0.start = st; bus0.rx_done = rv; bus0.rx_data = d;
    end else begin
      bus1.start = st; bus1.rx_done = rv; bus1.rx_data = d;
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    @(negedge clk);
    drive(sel, 1'b0, 1'b1, b);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 8'h00);
    repeat ($urandom_range(3, 5)) @(negedge clk);
  endtask

  task automatic send_word(input int sel, input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send_byte(sel, w[b*8 +: 8]);
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wq0.delete();
    wq1.delete();
  endtask

  task automatic check_result(input int sel, input words_t w, input int exp_n, input bit exp_done);
    wr_t q[$];
    int  lim;
    if (sel == 0) q = wq0; else q = wq1;
    chk("n_writes", 64'(q.size()), 64'(exp_n));
    lim = (q.size() < exp_n) ? q.size() : exp_n;
    for (int i = 0; i < lim; i++) begin
      chk("wr_addr",      64'(q[i].a),      64'(i));
      chk("wr_data",      64'(q[i].d),      64'(w[i]));
      chk("pre_addr",     64'(q[i].a_pre),  64'(i));
      chk("pre_data",     64'(q[i].d_pre),  64'(w[i]));
      chk("post_addr",    64'(q[i].a_post), 64'(i));
      chk("post_data",    64'(q[i].d_post), 64'(w[i]));
      chk("wr_one_cycle", 64'(q[i].wr_post), 64'(0));
    end
    chk("load_done",  64'(done_s[sel]), 64'(exp_done));
    chk("busy",       64'(busy_s[sel]), 64'(!exp_done));
    chk("word_count", 64'(wc_s[sel]),   64'(exp_n));
    if (exp_n > 0) begin
      chk("in_data_final", 64'(dat_s[sel]), 64'(w[exp_n-1]));
      chk("addr_final", 64'(addr_s[sel]), exp_done ? 64'(exp_n - 1) : 64'(exp_n));
    end
  endtask

  task automatic run_load(input int sel, input words_t w, input int n);
    do_reset();
    pulse_start(sel);
    for (int i = 0; i < n; i++) send_word(sel, w[i]);
    repeat (10) @(negedge clk);
  endtask

  vec_t tbl[$];

  task automatic add_vec(input int sel, input int n, input int exp_n, input bit exp_done,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] w4);
    vec_t v;
    v.sel = sel; v.n = n; v.exp_n = exp_n; v.exp_done = exp_done;
    v.w = '{default: '0};
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
    tbl.push_back(v);
  endtask

  initial begin
    words_t ws;
    int     en;
    bit     ed;
    bit     seen;

    add_vec(0, 1, 1, 1'b0, 32'h20010005, 0, 0, 0, 0);
    add_vec(0, 4, 4, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 32'hFC000000, 0);
    add_vec(0, 2, 1, 1'b1, 32'hFFFFFFFF, 32'h01020304, 0, 0, 0);
    add_vec(0, 3, 3, 1'b1, 32'hF8000000, 32'h7C000000, 32'hFC00ABCD, 0, 0);
    add_vec(1, 5, 4, 1'b1, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005);
    add_vec(1, 3, 3, 1'b1, 32'h00000001, 32'h00000002, 32'hFC000000, 0, 0);

    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wr",    64'(bus0.Wr), 64'(0));
    chk("rst_addr",  64'(bus0.Addr), 64'(0));
    chk("rst_data",  64'(bus0.In_Data), 64'(0));
    chk("rst_busy",  64'(bus0.busy), 64'(0));
    chk("rst_done",  64'(bus0.load_done), 64'(0));
    chk("rst_wc",    64'(bus0.word_count), 64'(0));
    chk("rst_bytes", 64'(dut.u_asm.byte_cnt), 64'(0));
    chk("rst_state", 64'(dut.state), 64'(ST_IDLE));
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      run_load(tbl[k].sel, tbl[k].w, tbl[k].n);
      check_result(tbl[k].sel, tbl[k].w, tbl[k].exp_n, tbl[k].exp_done);
      if (tbl[k].sel == 0 && !tbl[k].exp_done)
        chk("state_recv", 64'(dut.state), 64'(ST_RECV));
    end

    // Start together with rx_done in IDLE, then a start inside the load that must be ignored
    do_reset();
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h11);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    send_word(0, 32'h12345678);
    pulse_start(0);
    send_word(0, 32'hFC000007);
    repeat (10) @(negedge clk);
    ws = '{default: '0};
    ws[0] = 32'h12345678; ws[1] = 32'hFC000007;
    check_result(0, ws, 2, 1'b1);

    // Reset after two bytes of the second word, then a fresh load
    do_reset();
    pulse_start(0);
    send_word(0, 32'hCAFEF00D);
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    chk("pre_abort_writes", 64'(wq0.size()), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wr",    64'(bus0.Wr), 64'(0));
    chk("abort_addr",  64'(bus0.Addr), 64'(0));
    chk("abort_busy",  64'(bus0.busy), 64'(0));
    chk("abort_state", 64'(dut.state), 64'(ST_IDLE));
    chk("abort_bytes", 64'(dut.u_asm.byte_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wq0.delete();
    pulse_start(0);
    send_word(0, 32'hFC000042);
    repeat (10) @(negedge clk);
    ws = '{default: '0};
    ws[0] = 32'hFC000042;
    check_result(0, ws, 1, 1'b1);

    // Reset while Wr is high must drop it without a clock edge
    do_reset();
    pulse_start(0);
    send_byte(0, 8'hDE);
    send_byte(0, 8'hAD);
    send_byte(0, 8'hBE);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 8'hEF);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (bus0.Wr) seen = 1'b1;
    end
    chk("wr_seen", 64'(seen), 64'(1));
    #1 rst_n = 1'b0;
    #1 chk("wr_async_drop", 64'(bus0.Wr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

`ifdef LOADER_TIMEOUT_EN
    // Stalled partial word is dropped; the following four bytes form a clean word
    do_reset();
    pulse_start(0);
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    repeat (TO_CYC + 5) @(negedge clk);
    send_word(0, 32'h00000001);
    repeat (10) @(negedge clk);
    ws = '{default: '0};
    ws[0] = 32'h00000001;
    check_result(0, ws, 1, 1'b0);
`endif

    // Random loads on both instances against the word-level model
    for (int k = 0; k < 24; k++) begin
      int sel;
      int n;
      sel = k % 2;
      n = $urandom_range(1, 6);
      ws = '{default: '0};
      for (int i = 0; i < n; i++) begin
        ws[i] = $urandom;
        if ($urandom_range(0, 3) == 0) ws[i][31:26] = 6'h3f;
        else if (ws[i][31:26] == 6'h3f) ws[i][31] = 1'b0;
      end
      model(ws, n, (sel == 0) ? 2048 : 4, en, ed);
      run_load(sel, ws, n);
      check_result(sel, ws, en, ed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter len_addr, default 11, instruction-memory address width.
REQ-002 The block SHALL have parameter len_data, default 32, instruction word width.
REQ-003 The block SHALL have parameter ram_depth, default 2048, number of writable words.
REQ-004 One clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-005 The block SHALL have port clk  input  1  rising-edge system clock.
REQ-006 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have port start  input  1  one-cycle pulse that begins a program load.
REQ-008 The block SHALL have port rx_done  input  1  one-cycle strobe: rx_data holds a valid byte.
REQ-009 The block SHALL have port rx_data  input  8  received byte.
REQ-010 The block SHALL have port Wr  output  1  instruction-memory write strobe, registered.
REQ-011 The block SHALL have port Addr  output  len_addr  instruction-memory write address, registered.
REQ-012 The block SHALL have port In_Data  output  len_data  instruction word to write, registered.
REQ-013 The block SHALL have port busy  output  1  high from the start pulse until DONE.
REQ-014 The block SHALL have port load_done  output  1  high while in DONE.
REQ-015 The block SHALL have port word_count  output  len_addr+1  number of words written in the current load.

Function
REQ-016 The FSM SHALL have states IDLE, RECV, WRITE, HOLD and DONE.
REQ-017 In IDLE or DONE, start SHALL clear Addr, word_count and the byte counter, and go to RECV.
REQ-018 In RECV, each rx_done SHALL shift rx_data in, first byte = bits [31:24] (big-endian), with byte counter 0..3.
REQ-019 On the 4th byte, the block SHALL register the assembled word onto In_Data, clear the byte counter and go to WRITE on the next edge.
REQ-020 WRITE SHALL drive Wr=1 for exactly one cycle with Addr and In_Data already stable since the previous edge.
REQ-021 HOLD SHALL drive Wr=0 with Addr and In_Data unchanged for one cycle, so the memory samples stable data on the rising edge of Wr.
REQ-022 On leaving HOLD, word_count SHALL increment; the next state SHALL be DONE if In_Data[31:26]==6'b111111 (HALT) or Addr==ram_depth-1; otherwise Addr SHALL increment and the FSM SHALL return to RECV.
REQ-023 The HALT word SHALL be written to memory before entering DONE.
REQ-024 Addr SHALL never exceed ram_depth-1 and SHALL never wrap to 0 within a load.
REQ-025 rx_done in IDLE, WRITE, HOLD or DONE SHALL be ignored; the source guarantees at least 4 cycles between strobes.
REQ-026 start asserted in RECV, WRITE or HOLD SHALL be ignored.
REQ-027 If rx_done and start are asserted in the same cycle in IDLE, start SHALL take effect and the byte SHALL be discarded.

Reset
REQ-028 While rst_n=0, the block SHALL be in IDLE with Wr=0, Addr=0, In_Data=0, busy=0, load_done=0, word_count=0 and byte counter=0.
REQ-029 Reset asserted mid-load SHALL abort the load immediately; the partial word SHALL be discarded and Wr SHALL drop asynchronously.

Configuration
REQ-030 With LOADER_TIMEOUT_EN defined, RECV SHALL count cycles since the last rx_done and, after parameter timeout_cycles (default 100000), discard a partial word (byte counter to 0) while staying in RECV.
REQ-031 Without LOADER_TIMEOUT_EN, no timeout counter SHALL exist and a partial word SHALL wait indefinitely.

Structure
REQ-032 A shared package SHALL hold the FSM state encodings, the HALT opcode constant 6'b111111 and the byte count of 4 per word.
REQ-033 Byte assembly SHALL be a sub-module byte_assembler (shift register plus byte counter, word-valid pulse); the FSM and address logic SHALL remain in program_loader.

Verification
REQ-034 The bench SHALL check: start, then bytes 20,01,00,05 -> one Wr pulse, Addr=0, In_Data=0x20010005, word_count=1, FSM back in RECV.
REQ-035 The bench SHALL check: three words then FC,00,00,00 -> four Wr pulses at Addr 0..3, last In_Data=0xFC000000, load_done=1, busy=0.
REQ-036 The bench SHALL check: with ram_depth=4, five non-HALT words -> writes at Addr 0..3 only, DONE after the 4th, 5th word ignored.
REQ-037 The bench SHALL check: rst_n low after 2 bytes of the second word -> Wr=0, Addr=0, IDLE; a restarted load writes from Addr=0.
REQ-038 The bench SHALL check: Wr rising edge -> Addr and In_Data unchanged from one cycle before to one cycle after the edge.
REQ-039 With LOADER_TIMEOUT_EN, the bench SHALL check: 2 bytes, idle for timeout_cycles, then 4 bytes 00,00,00,01 -> a single write of 0x00000001 at Addr 0.
